// File: rtl/pbkdf2_sha512_ctrl.sv
// PBKDF2-HMAC-SHA512 iteration controller wrapped around an HMAC-SHA512 core.
// Optional abort input is enabled by defining PBKDF2_ABORT_EN.
module pbkdf2_sha512_ctrl #(
  parameter int ITER_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
`ifdef PBKDF2_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic              i_start,
  input  logic [1023:0]     i_key,
  input  logic [255:0]      i_salt,
  input  logic [31:0]       i_block_idx,
  input  logic [ITER_W-1:0] i_iterations,
  output logic              o_busy,
  output logic              o_done,
  output logic [511:0]      o_dk,
  output logic              o_hmac_reset,
  output logic              o_hmac_mode,
  output logic [1023:0]     o_hmac_key,
  output logic [511:0]      o_hmac_msg,
  input  logic              i_hmac_done,
  input  logic [511:0]      i_hmac_oH
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [ITER_W-1:0] ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ITER_W-1:0]   r_ceff;
  logic [ITER_W-1:0]   r_cnt;
  logic [511:0]        r_T;
  logic [511:0]        r_U;
  logic                r_first;
  logic                r_busy;
  logic                r_done;
  logic [511:0]        r_dk;
  logic                r_hmac_reset;
  logic                r_hmac_mode;
  logic [1023:0]       r_key;
  logic [511:0]        r_hmac_msg;
  logic                w_abort;

`ifdef PBKDF2_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Message and mode are loaded on entry to ARM so they are stable before the core leaves reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ceff       <= '0;
      r_cnt        <= '0;
      r_T          <= '0;
      r_U          <= '0;
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dk         <= '0;
      r_hmac_reset <= 1'b0;
      r_hmac_mode  <= 1'b0;
      r_key        <= '0;
      r_hmac_msg   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && (r_state != S_IDLE)) begin
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_hmac_reset <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state     <= S_ARM;
              r_busy      <= 1'b1;
              r_key       <= i_key;
              r_ceff      <= (i_iterations == '0) ? ONE : i_iterations;
              r_cnt       <= '0;
              r_T         <= '0;
              r_U         <= '0;
              r_first     <= 1'b1;
              r_hmac_mode <= 1'b0;
              r_hmac_msg  <= {i_salt, i_block_idx, 224'b0};
            end
          end
          S_ARM: begin
            r_state      <= S_RUN;
            r_hmac_reset <= 1'b1;
          end
          S_RUN: begin
            // The core result is only guaranteed valid in its done cycle.
            if (i_hmac_done) begin
              r_state      <= S_ACC;
              r_U          <= i_hmac_oH;
              r_T          <= r_T ^ i_hmac_oH;
              r_cnt        <= r_cnt + ONE;
              r_first      <= 1'b0;
              r_hmac_reset <= 1'b0;
            end
          end
          S_ACC: begin
            if (r_cnt != r_ceff) begin
              r_state     <= S_ARM;
              r_hmac_mode <= ~r_first;
              r_hmac_msg  <= r_U;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_dk    <= r_T;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_dk         = r_dk;
  assign o_hmac_reset = r_hmac_reset;
  assign o_hmac_mode  = r_hmac_mode;
  assign o_hmac_key   = r_key;
  assign o_hmac_msg   = r_hmac_msg;

endmodule

// File: tb/tb_pbkdf2_sha512_ctrl.sv
// Directed bench for pbkdf2_sha512_ctrl using a fixed-latency (5 cycle) HMAC stub.
// Define PBKDF2_ABORT_EN to also exercise the abort input.
module tb_pbkdf2_sha512_ctrl;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1023:0] key;
  logic [255:0]  salt;
  logic [31:0]   blockIdx;
  logic [31:0]   iterations;
  logic          busy;
  logic          done;
  logic [511:0]  dk;
  logic          hmacReset;
  logic          hmacMode;
  logic [1023:0] hmacKey;
  logic [511:0]  hmacMsg;
  logic          hmacDone;
  logic [511:0]  hmacOH;
`ifdef PBKDF2_ABORT_EN
  logic          abort;
`endif

  int passCount = 0;
  int checkCount = 0;

  int           stubCnt = 0;
  logic         prevReset = 1'b0;
  int           callNum = 0;
  int           callBase = 0;
  logic         stubConst = 1'b0;
  logic         modeLog [0:63];
  logic [511:0] msgLog  [0:63];
  logic         keyOkLog[0:63];

  always #5 clk = ~clk;

  pbkdf2_sha512_ctrl #(.ITER_W(32)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
`ifdef PBKDF2_ABORT_EN
    .i_abort      (abort),
`endif
    .i_start      (start),
    .i_key        (key),
    .i_salt       (salt),
    .i_block_idx  (blockIdx),
    .i_iterations (iterations),
    .o_busy       (busy),
    .o_done       (done),
    .o_dk         (dk),
    .o_hmac_reset (hmacReset),
    .o_hmac_mode  (hmacMode),
    .o_hmac_key   (hmacKey),
    .o_hmac_msg   (hmacMsg),
    .i_hmac_done  (hmacDone),
    .i_hmac_oH    (hmacOH)
  );

  // Stub core: done on the 5th cycle out of reset; call k returns {16{k}} or a constant.
  assign hmacDone = hmacReset && (stubCnt >= 4);
  assign hmacOH   = stubConst ? {16{32'hA5A5A5A5}} : {16{32'(callNum - callBase)}};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stubCnt   <= 0;
      prevReset <= 1'b0;
    end else begin
      prevReset <= hmacReset;
      stubCnt   <= hmacReset ? stubCnt + 1 : 0;
      if (hmacReset && !prevReset) begin
        modeLog[callNum % 64]  <= hmacMode;
        msgLog[callNum % 64]   <= hmacMsg;
        keyOkLog[callNum % 64] <= (hmacKey == key);
        callNum <= callNum + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [31:0] iters, input logic [31:0] blk, input logic sConst);
    @(negedge clk);
    stubConst  = sConst;
    callBase   = callNum;
    iterations = iters;
    blockIdx   = blk;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 300 && cycles < 0; n++) begin
      @(negedge clk);
      if (done) cycles = n;
    end
  endtask

  task automatic countDone(input int span, output int pulses);
    pulses = 0;
    for (int n = 0; n < span; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  int   cyc;
  int   pulses;
  logic found;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    key        = {64'h70617373776f7264, 960'b0};
    salt       = {8{32'h73616c74}};
    blockIdx   = 32'd0;
    iterations = 32'd0;
`ifdef PBKDF2_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 512'(busy), 512'd0);
    checkOutput("rst_done", 512'(done), 512'd0);
    checkOutput("rst_dk", dk, 512'd0);
    checkOutput("rst_hmac_reset", 512'(hmacReset), 512'd0);
    checkOutput("rst_mode", 512'(hmacMode), 512'd0);
    checkOutput("rst_key_zero", 512'(hmacKey == '0), 512'd1);
    checkOutput("rst_msg", hmacMsg, 512'd0);
    reset = 1'b0;

    // Three calls: modes 0,1,1; dk = 1^2^3 = 0; done on cycle 3*7+1.
    applyStimulus(32'd3, 32'd1, 1'b0);
    checkOutput("busy_after_accept", 512'(busy), 512'd1);
    waitDone(cyc);
    checkOutput("lat_c3", 512'(cyc), 512'd22);
    checkOutput("dk_c3", dk, {16{32'h00000000}});
    checkOutput("busy_in_done", 512'(busy), 512'd1);
    checkOutput("calls_c3", 512'(callNum - callBase), 512'd3);
    checkOutput("mode_call1", 512'(modeLog[callBase % 64]), 512'd0);
    checkOutput("mode_call2", 512'(modeLog[(callBase + 1) % 64]), 512'd1);
    checkOutput("mode_call3", 512'(modeLog[(callBase + 2) % 64]), 512'd1);
    checkOutput("msg1_salt", 512'(msgLog[callBase % 64][511:256]), 512'({8{32'h73616c74}}));
    checkOutput("msg1_blk", 512'(msgLog[callBase % 64][255:224]), 512'h00000001);
    checkOutput("msg1_zero", 512'(msgLog[callBase % 64][223:0]), 512'd0);
    checkOutput("msg2_is_U1", msgLog[(callBase + 1) % 64], {16{32'h00000001}});
    checkOutput("msg3_is_U2", msgLog[(callBase + 2) % 64], {16{32'h00000002}});
    checkOutput("key_to_core", 512'(keyOkLog[callBase % 64]), 512'd1);
    @(negedge clk);
    checkOutput("done_pulse_1cyc", 512'(done), 512'd0);
    checkOutput("busy_idle", 512'(busy), 512'd0);

    // iterations = 0 behaves as one call.
    applyStimulus(32'd0, 32'd2, 1'b1);
    waitDone(cyc);
    checkOutput("lat_c0", 512'(cyc), 512'd8);
    checkOutput("calls_c0", 512'(callNum - callBase), 512'd1);
    checkOutput("dk_c0", dk, {16{32'hA5A5A5A5}});

    // Start pulsed in RUN is ignored; dk = 1^2 = 3.
    applyStimulus(32'd2, 32'd1, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc);
    checkOutput("lat_rest_c2", 512'(cyc), 512'd11);
    checkOutput("calls_c2", 512'(callNum - callBase), 512'd2);
    checkOutput("dk_c2", dk, {16{32'h00000003}});

    // Start held from the DONE cycle: ignored there, accepted one cycle later.
    callBase = callNum;
    start = 1'b1;
    @(negedge clk);
    checkOutput("start_in_done_ignored", 512'(busy), 512'd0);
    @(negedge clk);
    checkOutput("start_next_accepted", 512'(busy), 512'd1);
    start = 1'b0;
    checkOutput("dk_held_new_run", dk, {16{32'h00000003}});
    waitDone(cyc);
    checkOutput("lat_rest_again", 512'(cyc), 512'd14);
    checkOutput("dk_again", dk, {16{32'h00000003}});

    // Asynchronous reset during RUN of the second call.
    applyStimulus(32'd3, 32'd1, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if ((callNum - callBase) == 2 && hmacReset) found = 1'b1;
    end
    checkOutput("reached_run2", 512'(found), 512'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 512'(busy), 512'd0);
    checkOutput("midrst_hmac_reset", 512'(hmacReset), 512'd0);
    checkOutput("midrst_dk", dk, 512'd0);
    checkOutput("midrst_msg", hmacMsg, 512'd0);
    checkOutput("midrst_mode", 512'(hmacMode), 512'd0);
    @(negedge clk);
    reset = 1'b0;
    countDone(40, pulses);
    checkOutput("midrst_no_done", 512'(pulses), 512'd0);
    applyStimulus(32'd1, 32'd5, 1'b1);
    waitDone(cyc);
    checkOutput("post_rst_lat", 512'(cyc), 512'd8);
    checkOutput("post_rst_dk", dk, {16{32'hA5A5A5A5}});

`ifdef PBKDF2_ABORT_EN
    applyStimulus(32'd3, 32'd1, 1'b0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_busy", 512'(busy), 512'd0);
    checkOutput("abort_hmac_reset", 512'(hmacReset), 512'd0);
    checkOutput("abort_dk_kept", dk, {16{32'hA5A5A5A5}});
    countDone(30, pulses);
    checkOutput("abort_no_done", 512'(pulses), 512'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
